// File: rtl/demux1to2_stream_pkg.sv
// demux1to2_stream_pkg
//   Shared definitions for the 1-to-2 stream demultiplexer:
//   - DATA_W   : default beat width, the source of the top's size default
//   - ROUTE_0/1: route select encodings carried on S0
//   - slot_state_e : per-route output slot state
//   - slot_can_load: a slot accepts a new beat when empty or draining
package demux1to2_stream_pkg;

  localparam int DATA_W = 8;

  localparam logic ROUTE_0 = 1'b0;
  localparam logic ROUTE_1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A one-entry slot can take a beat if it is empty or its consumer
  // is taking the current beat this cycle.
  function automatic logic slot_can_load(input logic valid, input logic ready);
    return (~valid) | ready;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry valid/ready output register used once per demux route.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     load        : write load_data into the slot this cycle (only when can_load)
//     load_data   : beat to store
//     out_valid   : slot holds a beat
//     out_ready   : consumer takes the beat this cycle
//     out_data    : stored beat, stable while out_valid=1 and out_ready=0
//     can_load    : slot is empty or draining this cycle
module demux_slot
  import demux1to2_stream_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         can_load
);

  slot_state_e  state_r;
  logic [W-1:0] data_r;

  // Slot state machine and data register; a load while FULL is a
  // same-cycle drain+reload, so there is no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SLOT_EMPTY;
      data_r  <= {W{1'b0}};
    end else begin
      case (state_r)
        SLOT_EMPTY: begin
          if (load) begin
            state_r <= SLOT_FULL;
            data_r  <= load_data;
          end else begin
            state_r <= SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            state_r <= SLOT_FULL;
            data_r  <= load_data;
          end else if (out_ready) begin
            state_r <= SLOT_EMPTY;
          end else begin
            state_r <= SLOT_FULL;
          end
        end
        default: begin
          state_r <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = (state_r == SLOT_FULL);
  assign out_data  = data_r;
  assign can_load  = slot_can_load(out_valid, out_ready);

endmodule

// File: rtl/demux1to2_stream.sv
// demux1to2_stream
//   Registered 1-to-2 stream demultiplexer with per-route beat counters.
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//     S0                      : route select (0 -> out0, 1 -> out1)
//     in_valid/in_ready/in_data : input stream; in_ready depends only on the
//                               selected route's slot, never on in_valid
//     out0_valid/ready/data   : route 0 output stream
//     out1_valid/ready/data   : route 1 output stream
//     cnt0, cnt1              : beats accepted per route, wrapping mod 2^CNT_W
module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int size  = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             S0,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [size-1:0]  in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [size-1:0]  out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [size-1:0]  out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             can_load0_s;
  logic             can_load1_s;
  logic             accept_s;
  logic             load0_s;
  logic             load1_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Route decode: only the selected slot's readiness gates the input.
  always_comb begin
    in_ready = 1'b0;
    load0_s  = 1'b0;
    load1_s  = 1'b0;
    if (S0 == ROUTE_1) begin
      in_ready = can_load1_s;
      load1_s  = in_valid & can_load1_s;
    end else begin
      in_ready = can_load0_s;
      load0_s  = in_valid & can_load0_s;
    end
  end

  assign accept_s = load0_s | load1_s;

  demux_slot #(.W(size)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0_s),
    .load_data (in_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data),
    .can_load  (can_load0_s)
  );

  demux_slot #(.W(size)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1_s),
    .load_data (in_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .can_load  (can_load1_s)
  );

  // Per-route accept counters; output handshakes do not touch them.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (load0_s) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt0_r <= cnt0_r;
      cnt1_r <= cnt1_r;
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb_demux1to2_stream
//   Directed scenarios followed by randomized traffic, compared against a
//   per-route slot/counter reference model held in this bench.
module tb_demux1to2_stream;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMOD = 1 << CW;

  logic          clk;
  logic          reset;
  logic          S0;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];
  int            m_cnt   [2];
  bit            m_init = 1'b0;

  demux1to2_stream #(.size(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .S0         (S0),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs while clk is low, check in_ready, advance the
  // model, then check registered outputs just after the rising edge.
  task automatic cycle(input logic rst, input logic s0, input logic iv,
                       input logic [DW-1:0] d, input logic r0, input logic r1);
    logic exp_ready;
    logic rdy [2];
    reset = rst; S0 = s0; in_valid = iv; in_data = d;
    out0_ready = r0; out1_ready = r1;
    rdy[0] = r0; rdy[1] = r1;
    #1;
    exp_ready = s0 ? (!m_valid[1] || r1) : (!m_valid[0] || r0);
    if (m_init) check_eq("in_ready", in_ready, exp_ready);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
        m_cnt[k]   = 0;
      end
      m_init = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (iv && exp_ready && (int'(s0) == k)) begin
          m_valid[k] = 1'b1;
          m_data[k]  = d;
          m_cnt[k]   = (m_cnt[k] + 1) % CMOD;
        end else if (rdy[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (m_init) begin
      check_eq("out0_valid", out0_valid, m_valid[0]);
      check_eq("out1_valid", out1_valid, m_valid[1]);
      if (m_valid[0] || rst) check_eq("out0_data", out0_data, m_data[0]);
      if (m_valid[1] || rst) check_eq("out1_data", out1_data, m_data[1]);
      check_eq("cnt0", cnt0, m_cnt[0]);
      check_eq("cnt1", cnt1, m_cnt[1]);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_cnt[k]   = 0;
    end

    // 1. reset held two clocks with in_valid high
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    check_eq("rst_out0_valid", out0_valid, 1'b0);
    check_eq("rst_cnt1", cnt1, 2'd0);

    // 2. single beat to route 0
    cycle(1'b0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
    check_eq("t2_out0_data", out0_data, 8'hF0);
    check_eq("t2_cnt0", cnt0, 2'd1);

    // 3. route 1 stalled for 3 clocks, route 0 still flows
    cycle(1'b0, 1'b1, 1'b1, 8'hF1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
      check_eq("t3_hold", out1_data, 8'hF1);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
    check_eq("t3_out0_data", out0_data, 8'h0A);

    // 4. streaming 1..5 into route 0 with consumer always ready
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
      check_eq("t4_stream", out0_data, 32'(i));
    end

    // 5. drain + reload in the same cycle
    cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0);
    check_eq("t5_valid", out0_valid, 1'b1);
    check_eq("t5_data", out0_data, 8'h22);

    // 6. counter wrap and reset while FULL
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
    check_eq("t6_wrap", cnt1, 2'd1);
    cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h78, 1'b0, 1'b0);
    check_eq("t6_rst_full", out1_valid, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
